mat_mul_loader: RTL and testbench
=================================

# mat_mul_loader

Upstream feeder for the matrix-multiply stage. Accepts operand matrices one row per beat over a valid/ready stream: N rows of matrix 1, then N rows of matrix 2. It assembles them into the flat `matrix_1`/`matrix_2` buses and issues a single-cycle `valid_in` pulse with the latched mode. Operands are then held stable until the multiplier signals completion, after which the next load is accepted.

## Interface
- `W_IN`, default 8: signed element width.
- `N`, default 8: matrix dimension (N×N), N ≥ 2.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cen`  in  1  clock enable; when low, all state, counters and outputs hold.
- `row_valid`  in  1  upstream row valid.
- `row_ready`  out  1  loader can accept a row.
- `row_data`  in  N*W_IN  one row; element c at bits [(c+1)*W_IN-1 : c*W_IN].
- `mode_in`  in  1  multiply mode; sampled with row 0 of matrix 1.
- `mm_done`  in  1  multiplier completion (`valid_out` of the multiply stage).
- `matrix_1`  out  N*N*W_IN  assembled operand 1.
- `matrix_2`  out  N*N*W_IN  assembled operand 2.
- `mm_valid_in`  out  1  operand-valid pulse to the multiplier.
- `mm_mode`  out  1  latched mode.
- `busy`  out  1  load in progress or job outstanding.

## Operation
- Transfer: `row_valid && row_ready && cen` in the same cycle.
- Packing: element (r,c) at bits [(r*N+c+1)*W_IN-1 : (r*N+c)*W_IN]. Row 0 occupies the LSBs. Rows are stored verbatim, with no sign manipulation.
- Row counter `rcnt`, width clog2(N), runs 0..N-1 and wraps to 0 on the N-th transfer of each matrix.
- FSM:
  - LOAD_A: `row_ready`=1. Each transfer writes row `rcnt` of `matrix_1`. The transfer at `rcnt`=0 also latches `mode_in` into `mm_mode`. Transfer at `rcnt`=N-1 goes to LOAD_B.
  - LOAD_B: `row_ready`=1. Each transfer writes row `rcnt` of `matrix_2`. Transfer at `rcnt`=N-1 goes to ISSUE.
  - ISSUE: `row_ready`=0, `mm_valid_in`=1. One cen-enabled cycle, then go to WAIT.
  - WAIT: `row_ready`=0. `mm_done` with `cen` goes to LOAD_A.
- `mm_done` is ignored in every state except WAIT.
- `row_ready` = `cen` && (state ∈ {LOAD_A, LOAD_B}), combinational.
- `busy` = (state ≠ LOAD_A) || (`rcnt` ≠ 0).
- `matrix_1`, `matrix_2` and `mm_mode` change only on row transfers. They are therefore stable from ISSUE through WAIT.
- Reset mid-operation: partial rows are discarded and the FSM returns to LOAD_A with `rcnt`=0. Matrices are cleared.

## Timing
- Reset values: `matrix_1`=0, `matrix_2`=0, `mm_valid_in`=0, `mm_mode`=0, `busy`=0. `row_ready` follows `cen` (state LOAD_A).
- Rows are written on the clock edge of the transfer and are visible on the output buses the next cycle.
- `mm_valid_in` is a registered output (state == ISSUE). It rises the cycle after the last B-row transfer.
- `mm_valid_in` is high for exactly one cen-enabled cycle. If `cen` is low during ISSUE, the pulse is extended by the held cycles.
- Minimum job: 2N transfer cycles, plus 1 ISSUE cycle, plus the multiplier latency.
- LOAD_A is re-entered, with `row_ready`=1, the cycle after `mm_done` is sampled in WAIT.
- A row may be accepted on every cycle, including back-to-back across the A→B boundary with no bubble.
- `rst` overrides `cen`.

## Test plan
- N=2, W_IN=8. Send A rows {0x02,0x01}, {0x04,0x03}, then B rows {0x06,0x05}, {0x08,0x07}, back-to-back, with `mode_in`=1 on the first beat.
  - Required: `matrix_1`=0x04030201 and `matrix_2`=0x08070605.
  - `mm_valid_in` is a single pulse the cycle after the 4th transfer, with `mm_mode`=1.
- Hold `row_valid` high in WAIT → `row_ready`=0 and no rows are consumed.
  - Pulse `mm_done` → `row_ready`=1 next cycle, and the next row lands in row 0 of `matrix_1`.
- Insert random `row_valid` gaps and `cen`-low cycles during load → same packed result as the gap-free case.
  - With `cen` low during ISSUE, `mm_valid_in` stays high until the next cen-high cycle, then drops.
- Assert `mm_done` during LOAD_A and during ISSUE → ignored; no state change, no extra pulse.
- Assert `rst` after 3 rows (mid-B) → all outputs return to reset values.
  - A fresh 4-row load then produces a correct single `mm_valid_in` pulse.
- `mode_in` toggling on non-first beats → `mm_mode` reflects only the value sampled with row 0 of A.

Source files
------------

// File: rtl/mat_mul_loader.sv
// Row-streaming operand loader: packs N rows of matrix 1 then N rows of matrix 2,
// then pulses mm_valid_in and holds the operands until the multiplier reports done.
module mat_mul_loader #(
  parameter int W_IN = 8,
  parameter int N    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [N*W_IN-1:0]      row_data,
  input  logic                   mode_in,
  input  logic                   mm_done,
  output logic [N*N*W_IN-1:0]    matrix_1,
  output logic [N*N*W_IN-1:0]    matrix_2,
  output logic                   mm_valid_in,
  output logic                   mm_mode,
  output logic                   busy
);

  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [RW-1:0]   rcnt;
  logic            xfer;
  logic            last_row;

  assign last_row = (rcnt == RW'(N - 1));
  assign xfer     = row_valid && row_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
    end else if (cen) begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    row_ready  = 1'b0;
    unique case (state)
      LOAD_A: begin
        row_ready = cen;
        if (xfer && last_row) next_state = LOAD_B;
      end
      LOAD_B: begin
        row_ready = cen;
        if (xfer && last_row) next_state = ISSUE;
      end
      ISSUE: next_state = WAIT;
      WAIT:  if (mm_done) next_state = LOAD_A;
      default: next_state = LOAD_A;
    endcase
  end

  // Datapath: operands and mode only move on an accepted row, so they stay
  // stable from ISSUE through WAIT without extra hold logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt     <= '0;
      matrix_1 <= '0;
      matrix_2 <= '0;
      mm_mode  <= 1'b0;
    end else if (cen && xfer) begin
      rcnt <= last_row ? '0 : rcnt + RW'(1);
      if (state == LOAD_A) begin
        matrix_1[int'(rcnt)*N*W_IN +: N*W_IN] <= row_data;
        if (rcnt == '0) mm_mode <= mode_in;
      end else begin
        matrix_2[int'(rcnt)*N*W_IN +: N*W_IN] <= row_data;
      end
    end
  end

  assign mm_valid_in = (state == ISSUE);
  assign busy        = (state != LOAD_A) || (rcnt != '0);

endmodule

// File: tb/tb_mat_mul_loader.sv
// Directed self-checking bench for mat_mul_loader at N=2, W_IN=8.
module tb_mat_mul_loader;
  localparam int W_IN = 8;
  localparam int N    = 2;

  logic                 clk = 1'b0;
  logic                 rst, cen, row_valid, row_ready, mode_in, mm_done;
  logic                 mm_valid_in, mm_mode, busy;
  logic [N*W_IN-1:0]    row_data;
  logic [N*N*W_IN-1:0]  matrix_1, matrix_2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_mul_loader #(.W_IN(W_IN), .N(N)) dut (
    .clk(clk), .rst(rst), .cen(cen), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .mode_in(mode_in), .mm_done(mm_done), .matrix_1(matrix_1),
    .matrix_2(matrix_2), .mm_valid_in(mm_valid_in), .mm_mode(mm_mode), .busy(busy)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Four back-to-back rows; first beat carries m0, later beats carry mo.
  task automatic load4(input logic [15:0] a0, a1, b0, b1, input logic m0, mo);
    row_valid = 1'b1; row_data = a0; mode_in = m0; step;
    row_data = a1; mode_in = mo; step;
    row_data = b0; step;
    row_data = b1; step;
    row_valid = 1'b0; mode_in = 1'b0; row_data = '0;
  endtask

  task automatic finish_job;
    mm_done = 1'b1; step; mm_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; step;
    checks++; if (matrix_1 !== 32'h0) begin errors++; $display("FAIL reset_m1 got %h want 0", matrix_1); end
    checks++; if (matrix_2 !== 32'h0) begin errors++; $display("FAIL reset_m2 got %h want 0", matrix_2); end
    checks++; if (mm_valid_in !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mm_valid_in); end
    checks++; if (mm_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", mm_mode); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (row_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", row_ready); end
    cen = 1'b0; #1;
    checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL ready_follows_cen got %b want 0", row_ready); end
    cen = 1'b1; rst = 1'b0; step;
    checks++; if (busy !== 1'b0 || row_ready !== 1'b1) begin errors++; $display("FAIL idle_after_reset got busy=%b ready=%b want 0/1", busy, row_ready); end
  endtask

  task automatic test_basic;
    row_valid = 1'b1; row_data = 16'h0201; mode_in = 1'b1; step;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_row0 got %b want 1", busy); end
    checks++; if (matrix_1[15:0] !== 16'h0201) begin errors++; $display("FAIL row0_visible got %h want 0201", matrix_1[15:0]); end
    row_data = 16'h0403; mode_in = 1'b0; step;
    row_data = 16'h0605; step;
    checks++; if (mm_valid_in !== 1'b0 || row_ready !== 1'b1) begin errors++; $display("FAIL no_bubble_b got valid=%b ready=%b want 0/1", mm_valid_in, row_ready); end
    row_data = 16'h0807; step;
    row_valid = 1'b0;
    checks++; if (mm_valid_in !== 1'b1) begin errors++; $display("FAIL basic_pulse got %b want 1", mm_valid_in); end
    checks++; if (matrix_1 !== 32'h04030201) begin errors++; $display("FAIL basic_m1 got %h want 04030201", matrix_1); end
    checks++; if (matrix_2 !== 32'h08070605) begin errors++; $display("FAIL basic_m2 got %h want 08070605", matrix_2); end
    checks++; if (mm_mode !== 1'b1) begin errors++; $display("FAIL basic_mode got %b want 1", mm_mode); end
    checks++; if (row_ready !== 1'b0) begin errors++; $display("FAIL issue_ready got %b want 0", row_ready); end
    step;
    checks++; if (mm_valid_in !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_pulse got valid=%b busy=%b want 0/1", mm_valid_in, busy); end
  endtask

  task automatic test_wait_hold;
    row_valid = 1'b1; row_data = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (row_ready !== 1'b0 || matrix_1 !== 32'h04030201) begin errors++; $display("FAIL wait_hold got ready=%b m1=%h want 0/04030201", row_ready, matrix_1); end
    end
    finish_job;
    checks++; if (row_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_reenter got ready=%b busy=%b want 1/0", row_ready, busy); end
    step;
    row_valid = 1'b0;
    checks++; if (matrix_1 !== 32'h0403AAAA) begin errors++; $display("FAIL next_row0 got %h want 0403aaaa", matrix_1); end
    row_valid = 1'b1; row_data = 16'h1111; step;
    row_data = 16'h2222; step;
    row_data = 16'h3333; step;
    row_valid = 1'b0;
    checks++; if (matrix_1 !== 32'h1111AAAA || matrix_2 !== 32'h33332222 || mm_mode !== 1'b0) begin errors++; $display("FAIL second_job got m1=%h m2=%h mode=%b want 1111aaaa/33332222/0", matrix_1, matrix_2, mm_mode); end
    step;
    finish_job;
  endtask

  task automatic test_gaps;
    logic [15:0] rows [4];
    logic        got;
    rows[0] = 16'h0201; rows[1] = 16'h0403; rows[2] = 16'h0605; rows[3] = 16'h0807;
    for (int r = 0; r < 4; r++) begin
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        cen = ($urandom_range(0, 3) != 0);
        row_valid = ($urandom_range(0, 2) != 0);
        row_data = rows[r];
        mode_in = (r == 0) ? 1'b1 : 1'(t);
        #1;
        got = row_valid && row_ready;
        @(posedge clk); #1;
      end
      if (!got) begin
        errors++; checks++; $display("FAIL gap_timeout row %0d got no transfer want transfer", r);
      end
    end
    row_valid = 1'b0; mode_in = 1'b0;
    checks++; if (mm_valid_in !== 1'b1) begin errors++; $display("FAIL gap_pulse got %b want 1", mm_valid_in); end
    checks++; if (matrix_1 !== 32'h04030201 || matrix_2 !== 32'h08070605 || mm_mode !== 1'b1) begin errors++; $display("FAIL gap_pack got m1=%h m2=%h mode=%b want 04030201/08070605/1", matrix_1, matrix_2, mm_mode); end
    cen = 1'b0; step; step;
    checks++; if (mm_valid_in !== 1'b1) begin errors++; $display("FAIL issue_cen_hold got %b want 1", mm_valid_in); end
    cen = 1'b1; step;
    checks++; if (mm_valid_in !== 1'b0) begin errors++; $display("FAIL issue_cen_release got %b want 0", mm_valid_in); end
    finish_job;
  endtask

  task automatic test_done_ignored;
    mm_done = 1'b1; step; mm_done = 1'b0;
    checks++; if (busy !== 1'b0 || row_ready !== 1'b1 || mm_valid_in !== 1'b0) begin errors++; $display("FAIL done_in_load_a got busy=%b ready=%b valid=%b want 0/1/0", busy, row_ready, mm_valid_in); end
    load4(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1, 1'b1);
    mm_done = 1'b1; step; mm_done = 1'b0;
    checks++; if (busy !== 1'b1 || row_ready !== 1'b0 || mm_valid_in !== 1'b0) begin errors++; $display("FAIL done_in_issue got busy=%b ready=%b valid=%b want 1/0/0", busy, row_ready, mm_valid_in); end
    step;
    checks++; if (mm_valid_in !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL no_extra_pulse got valid=%b busy=%b want 0/1", mm_valid_in, busy); end
    finish_job;
  endtask

  task automatic test_reset_mid;
    row_valid = 1'b1; row_data = 16'h0A0B; mode_in = 1'b1; step;
    row_data = 16'h0C0D; mode_in = 1'b0; step;
    row_data = 16'h0E0F; step;
    row_valid = 1'b0; rst = 1'b1; step; rst = 1'b0;
    checks++; if (matrix_1 !== 32'h0 || matrix_2 !== 32'h0 || mm_mode !== 1'b0) begin errors++; $display("FAIL midreset_regs got m1=%h m2=%h mode=%b want 0/0/0", matrix_1, matrix_2, mm_mode); end
    checks++; if (busy !== 1'b0 || mm_valid_in !== 1'b0 || row_ready !== 1'b1) begin errors++; $display("FAIL midreset_ctrl got busy=%b valid=%b ready=%b want 0/0/1", busy, mm_valid_in, row_ready); end
    load4(16'h1122, 16'h3344, 16'h5566, 16'h7788, 1'b0, 1'b1);
    checks++; if (mm_valid_in !== 1'b1 || matrix_1 !== 32'h33441122 || matrix_2 !== 32'h77885566) begin errors++; $display("FAIL fresh_load got valid=%b m1=%h m2=%h want 1/33441122/77885566", mm_valid_in, matrix_1, matrix_2); end
    checks++; if (mm_mode !== 1'b0) begin errors++; $display("FAIL mode_toggle0 got %b want 0", mm_mode); end
    step;
    checks++; if (mm_valid_in !== 1'b0) begin errors++; $display("FAIL fresh_single got %b want 0", mm_valid_in); end
    finish_job;
  endtask

  task automatic test_mode;
    load4(16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b1, 1'b0);
    checks++; if (mm_mode !== 1'b1 || matrix_1 !== 32'h02020101 || matrix_2 !== 32'h04040303) begin errors++; $display("FAIL mode_toggle1 got mode=%b m1=%h m2=%h want 1/02020101/04040303", mm_mode, matrix_1, matrix_2); end
    step;
    finish_job;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; row_valid = 1'b0; row_data = '0; mode_in = 1'b0; mm_done = 1'b0;
    step; step;
    test_reset;
    test_basic;
    test_wait_hold;
    test_gaps;
    test_done_ignored;
    test_reset_mid;
    test_mode;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
